// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code map, arbiter state encoding and op classification helper.
package alu_pkg;

  localparam int unsigned ALU_W    = 32;
  localparam int unsigned ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_NOT  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_EQ   = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Codes 1100-1111 are reserved and produce an error response.
  function automatic logic op_reserved(input logic [ALU_OP_W-1:0] op);
    return (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU; all outputs are held at zero while alu_enable_i is low.
module alu
  import alu_pkg::*;
(
  input  logic                alu_enable_i,
  input  logic [ALU_W-1:0]    r1_i,
  input  logic [ALU_W-1:0]    r2_i,
  input  logic [ALU_OP_W-1:0] op_i,
  output logic [ALU_W-1:0]    sum_o,
  output logic                overflow_o
);

  logic [4:0]       shamt;
  logic [ALU_W-1:0] add_res;
  logic [ALU_W-1:0] sub_res;

  assign shamt   = r2_i[4:0];
  assign add_res = r1_i + r2_i;
  assign sub_res = r1_i - r2_i;

  always_comb begin
    sum_o      = '0;
    overflow_o = 1'b0;
    if (alu_enable_i) begin
      case (op_i)
        ALU_ADD: begin
          sum_o      = add_res;
          // Signed overflow: operands agree in sign but the result does not.
          overflow_o = (r1_i[31] == r2_i[31]) && (add_res[31] != r1_i[31]);
        end
        ALU_SUB: begin
          sum_o      = sub_res;
          overflow_o = (r1_i[31] != r2_i[31]) && (sub_res[31] != r1_i[31]);
        end
        ALU_NOT:  sum_o = ~r1_i;
        ALU_AND:  sum_o = r1_i & r2_i;
        ALU_OR:   sum_o = r1_i | r2_i;
        ALU_XOR:  sum_o = r1_i ^ r2_i;
        ALU_SLT:  sum_o = {31'd0, ($signed(r1_i) < $signed(r2_i))};
        ALU_SLTU: sum_o = {31'd0, (r1_i < r2_i)};
        ALU_SLL:  sum_o = r1_i << shamt;
        ALU_SRL:  sum_o = r1_i >> shamt;
        ALU_SRA:  sum_o = $signed(r1_i) >>> shamt;
        ALU_EQ:   sum_o = {31'd0, (r1_i == r2_i)};
        default: begin
          sum_o      = '0;
          overflow_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic rr_last_i,
  output logic gnt_o,
  output logic any_o
);

  always_comb begin
    any_o = valid0_i | valid1_i;
    if (valid0_i && !valid1_i) begin
      gnt_o = 1'b0;
    end else if (valid1_i && !valid0_i) begin
      gnt_o = 1'b1;
    end else begin
      gnt_o = ~rr_last_i;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: accept, execute for one cycle, hold the result
// on the owner's response channel until it is consumed.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned OP_W    = 4,
  parameter bit          RR_INIT = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_0,
  input  logic            req_valid_1,
  output logic            req_ready_0,
  output logic            req_ready_1,
  input  logic [W-1:0]    req_r1_0,
  input  logic [W-1:0]    req_r1_1,
  input  logic [W-1:0]    req_r2_0,
  input  logic [W-1:0]    req_r2_1,
  input  logic [OP_W-1:0] req_op_0,
  input  logic [OP_W-1:0] req_op_1,
  output logic            resp_valid_0,
  output logic            resp_valid_1,
  input  logic            resp_ready_0,
  input  logic            resp_ready_1,
  output logic [W-1:0]    resp_sum,
  output logic            resp_overflow,
  output logic            resp_err,
  output logic            busy
);

  arb_state_e      state_q, state_d;
  logic [W-1:0]    r1_q, r1_d;
  logic [W-1:0]    r2_q, r2_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            owner_q;
  logic            rr_last_q;
  logic [W-1:0]    sum_q;
  logic            ovf_q;
  logic            err_q;

  logic            gnt;
  logic            any_valid;
  logic            accept;
  logic            alu_en;
  logic [W-1:0]    alu_sum;
  logic            alu_ovf;
  logic            owner_ready;

  rr_arb2 u_rr_arb2 (
    .valid0_i  (req_valid_0),
    .valid1_i  (req_valid_1),
    .rr_last_i (rr_last_q),
    .gnt_o     (gnt),
    .any_o     (any_valid)
  );

  alu u_alu (
    .alu_enable_i (alu_en),
    .r1_i         (r1_q),
    .r2_i         (r2_q),
    .op_i         (op_q),
    .sum_o        (alu_sum),
    .overflow_o   (alu_ovf)
  );

  assign owner_ready = owner_q ? resp_ready_1 : resp_ready_0;
  assign r1_d        = gnt ? req_r1_1 : req_r1_0;
  assign r2_d        = gnt ? req_r2_1 : req_r2_0;
  assign op_d        = gnt ? req_op_1 : req_op_0;

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    req_ready_0  = 1'b0;
    req_ready_1  = 1'b0;
    resp_valid_0 = 1'b0;
    resp_valid_1 = 1'b0;
    alu_en       = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready is gated by rst_n so no handshake is offered while held in reset.
        if (any_valid && rst_n) begin
          accept      = 1'b1;
          req_ready_0 = ~gnt;
          req_ready_1 = gnt;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        alu_en  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        resp_valid_0 = ~owner_q;
        resp_valid_1 = owner_q;
        if (owner_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= ~RR_INIT;
      owner_q   <= 1'b0;
      r1_q      <= '0;
      r2_q      <= '0;
      op_q      <= '0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        r1_q      <= r1_d;
        r2_q      <= r2_d;
        op_q      <= op_d;
        owner_q   <= gnt;
        rr_last_q <= gnt;
      end
      if (state_q == EXEC) begin
        sum_q <= alu_sum;
        ovf_q <= alu_ovf;
        err_q <= op_reserved(op_q);
      end
    end
  end

  assign resp_sum      = sum_q;
  assign resp_overflow = ovf_q;
  assign resp_err      = err_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers push expected results on accept, a monitor pops on response.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_r1_0, req_r1_1, req_r2_0, req_r2_1;
  logic [3:0]  req_op_0, req_op_1;
  logic        resp_valid_0, resp_valid_1;
  logic        resp_ready_0, resp_ready_1;
  logic [31:0] resp_sum;
  logic        resp_overflow, resp_err, busy;

  always #5 clk = ~clk;

  alu_arbiter #(.W(32), .OP_W(4), .RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_r1_0(req_r1_0), .req_r1_1(req_r1_1),
    .req_r2_0(req_r2_0), .req_r2_1(req_r2_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_sum(resp_sum), .resp_overflow(resp_overflow), .resp_err(resp_err),
    .busy(busy)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        ovf;
    logic        err;
  } resp_t;

  int    errors = 0;
  int    checks = 0;
  resp_t exp_q0[$];
  resp_t exp_q1[$];
  int    grant_log[$];
  bit    rand_rdy_en = 1'b0;
  bit    tb_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference computed with 64-bit signed arithmetic; overflow means the true result is unrepresentable.
  function automatic resp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    resp_t       r;
    longint      sa;
    longint      sb;
    longint      s;
    int unsigned sh;
    r  = '0;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[4:0];
    case (op)
      4'd0: begin s = sa + sb; r.sum = 32'(s); r.ovf = (s != longint'($signed(r.sum))); end
      4'd1: begin s = sa - sb; r.sum = 32'(s); r.ovf = (s != longint'($signed(r.sum))); end
      4'd2:  r.sum = ~a;
      4'd3:  r.sum = a & b;
      4'd4:  r.sum = a | b;
      4'd5:  r.sum = a ^ b;
      4'd6:  r.sum = (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  r.sum = (a < b) ? 32'd1 : 32'd0;
      4'd8:  r.sum = a << sh;
      4'd9:  r.sum = a >> sh;
      4'd10: begin s = sa >>> sh; r.sum = 32'(s); end
      4'd11: r.sum = (a == b) ? 32'd1 : 32'd0;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input int who, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int bound);
    bit done = 1'b0;
    @(posedge clk); #1;
    if (who == 0) begin req_valid_0 = 1'b1; req_op_0 = op; req_r1_0 = a; req_r2_0 = b; end
    else          begin req_valid_1 = 1'b1; req_op_1 = op; req_r1_1 = a; req_r2_1 = b; end
    for (int c = 0; c < bound && !done; c++) begin
      @(negedge clk);
      if ((who == 0) ? req_ready_0 : req_ready_1) begin
        if (who == 0) exp_q0.push_back(model(op, a, b));
        else          exp_q1.push_back(model(op, a, b));
        grant_log.push_back(who);
        done = 1'b1;
        @(posedge clk); #1;
      end
    end
    if (!done) chk($sformatf("accept_timeout_%0d", who), 0, 1);
    if (who == 0) req_valid_0 = 1'b0;
    else          req_valid_1 = 1'b0;
  endtask

  task automatic wait_resp(input int who, input int bound);
    bit seen = 1'b0;
    for (int c = 0; c < bound && !seen; c++) begin
      @(negedge clk);
      seen = (who == 0) ? resp_valid_0 : resp_valid_1;
    end
    chk($sformatf("resp_valid_seen_%0d", who), seen, 1);
  endtask

  // Grant-policy checker: ready only for a valid requester, only in IDLE, ties alternate.
  always @(negedge clk) begin
    if (!rst_n) begin
      tb_last = 1'b1;
    end else begin
      if (busy) chk("ready_in_busy", req_ready_0 | req_ready_1, 0);
      if (req_ready_0 || req_ready_1) begin
        chk("ready_onehot", req_ready_0 & req_ready_1, 0);
        chk("ready_wo_valid", (req_ready_0 & ~req_valid_0) | (req_ready_1 & ~req_valid_1), 0);
        if (req_valid_0 && req_valid_1) chk("rr_tie", req_ready_1, !tb_last);
        tb_last = req_ready_1;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n) begin
      if (resp_valid_0 || resp_valid_1) chk("resp_onehot", resp_valid_0 & resp_valid_1, 0);
      if (resp_valid_0 && resp_ready_0) begin
        chk("resp0_expected", exp_q0.size(), 1);
        if (exp_q0.size() != 0) begin
          e = exp_q0.pop_front();
          chk("resp0_sum", resp_sum, e.sum);
          chk("resp0_ovf", resp_overflow, e.ovf);
          chk("resp0_err", resp_err, e.err);
        end
      end
      if (resp_valid_1 && resp_ready_1) begin
        chk("resp1_expected", exp_q1.size(), 1);
        if (exp_q1.size() != 0) begin
          e = exp_q1.pop_front();
          chk("resp1_sum", resp_sum, e.sum);
          chk("resp1_ovf", resp_overflow, e.ovf);
          chk("resp1_err", resp_err, e.err);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy_en) begin
      #1;
      resp_ready_0 = ($urandom_range(0, 3) != 0);
      resp_ready_1 = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid_0", resp_valid_0, 0);
    chk("rst_resp_valid_1", resp_valid_1, 0);
    chk("rst_busy", busy, 0);
    exp_q0.delete();
    exp_q1.delete();
    #8;
    rst_n = 1'b1;
  endtask

  initial begin
    bit leak;
    int drain;
    rst_n = 1'b0;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    req_r1_0 = '0; req_r1_1 = '0; req_r2_0 = '0; req_r2_1 = '0;
    req_op_0 = '0; req_op_1 = '0;
    resp_ready_0 = 1'b0; resp_ready_1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_overflow, resp_err, busy}, 0);
    chk("reset_sum", resp_sum, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // 1: overflowing add, latency
    resp_ready_0 = 1'b1;
    issue(0, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 20);
    chk("t1_exec_no_resp", resp_valid_0, 0);
    chk("t1_exec_busy", busy, 1);
    @(posedge clk); #1;
    chk("t1_resp_valid", resp_valid_0, 1);
    repeat (3) @(posedge clk);

    // 2: tie from reset goes to requester 0, then 1
    do_reset();
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    grant_log.delete();
    fork
      issue(0, ALU_SUB,  32'd5, 32'd7, 20);
      issue(1, ALU_SLTU, 32'd5, 32'd7, 20);
    join
    chk("t2_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t2_first_grant", grant_log[0], 0);
      chk("t2_second_grant", grant_log[1], 1);
    end
    repeat (5) @(posedge clk);

    // 3: response stall holds result and blocks the other requester
    resp_ready_1 = 1'b0;
    issue(1, ALU_SRA, 32'h8000_0000, 32'd4, 20);
    fork
      issue(0, ALU_ADD, 32'd3, 32'd4, 60);
      begin
        wait_resp(1, 4);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("t3_hold_valid", resp_valid_1, 1);
          chk("t3_hold_sum", resp_sum, 32'hF800_0000);
          chk("t3_no_ready0", req_ready_0, 0);
        end
        @(posedge clk); #1;
        resp_ready_1 = 1'b1;
      end
    join
    repeat (5) @(posedge clk);

    // 4: reserved op code
    issue(0, 4'b1110, $urandom, $urandom, 20);
    repeat (4) @(posedge clk);

    // 5: reset while in RESP, then first tie favours requester 0
    resp_ready_0 = 1'b0;
    issue(0, ALU_ADD, 32'd1, 32'd2, 20);
    wait_resp(0, 4);
    do_reset();
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    grant_log.delete();
    fork
      issue(0, ALU_OR,  32'h0F0F_0000, 32'h0000_F0F0, 20);
      issue(1, ALU_XOR, 32'hFFFF_0000, 32'h00FF_FF00, 20);
    join
    chk("t5_grants", grant_log.size(), 2);
    if (grant_log.size() != 0) chk("t5_first_after_reset", grant_log[0], 0);
    repeat (5) @(posedge clk);

    // 6: one-cycle valid pulse while busy is never accepted
    resp_ready_1 = 1'b0;
    issue(1, ALU_AND, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 20);
    wait_resp(1, 4);
    @(posedge clk); #1;
    req_valid_0 = 1'b1; req_op_0 = ALU_ADD; req_r1_0 = 32'd9; req_r2_0 = 32'd9;
    @(negedge clk);
    chk("t6_pulse_not_ready", req_ready_0, 0);
    @(posedge clk); #1;
    req_valid_0 = 1'b0;
    resp_ready_1 = 1'b1;
    leak = 1'b0;
    repeat (8) begin
      @(negedge clk);
      leak |= resp_valid_0;
    end
    chk("t6_no_resp0", leak, 0);
    chk("t6_no_exp0", exp_q0.size(), 0);

    // Randomised traffic with random response back-pressure
    rand_rdy_en = 1'b1;
    fork
      for (int n = 0; n < 30; n++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        issue(0, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11)),
              pick_operand(), pick_operand(), 200);
      end
      for (int n = 0; n < 30; n++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        issue(1, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11)),
              pick_operand(), pick_operand(), 200);
      end
    join
    rand_rdy_en = 1'b0;
    @(posedge clk); #1;
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    drain = 0;
    while ((exp_q0.size() + exp_q1.size()) != 0 && drain < 50) begin
      @(posedge clk);
      drain++;
    end
    chk("random_drained", exp_q0.size() + exp_q1.size(), 0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
